// File: rtl/das_pkg.sv
// Shared types and width derivations for the delay-and-sum beamformer.
package das_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } das_state_e;

    // Channel counter / index width; never below one bit.
    function automatic int unsigned idx_w(input int unsigned num_mics);
        return (num_mics > 1) ? $clog2(num_mics) : 1;
    endfunction

    // Accumulator width: enough headroom for NUM_MICS full-scale samples.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned num_mics);
        return data_w + $clog2(num_mics);
    endfunction

endpackage

// File: rtl/das_ring_ram.sv
// Simple dual-port history RAM: one write port, one synchronous read port.
module das_ring_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 144
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/das_beamformer.sv
// Delay-and-sum beamformer: circular sample history, per-channel delays with
// atomic shadow->active commit, serial accumulate, shift and saturate.
module das_beamformer
    import das_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_MICS = 9,
    parameter int unsigned DELAY_W  = 8,
    parameter int unsigned SHIFT    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_MICS*DATA_W-1:0]   in_data,
    input  logic                         dly_wr_en,
    input  logic [$clog2(NUM_MICS)-1:0]  dly_wr_idx,
    input  logic [DELAY_W-1:0]           dly_wr_val,
    input  logic                         dly_commit,
    output logic                         commit_pending,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sat
);

    localparam int unsigned IDX_W  = idx_w(NUM_MICS);
    localparam int unsigned ACC_W  = acc_w(DATA_W, NUM_MICS);
    localparam int unsigned ROW_W  = NUM_MICS * DATA_W;
    localparam int unsigned DEPTH  = 1 << DELAY_W;
    localparam int unsigned FILL_W = DELAY_W + 1;
    localparam int          SAT_MAX_I = (1 << (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_I - 1);

    das_state_e               state_q, state_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic [DELAY_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DELAY_W-1:0]       base_q, base_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rd_vld_q, rd_vld_d;
    logic                     rd_zero_q, rd_zero_d;
    logic [IDX_W-1:0]         rd_k_q, rd_k_d;
    logic [DELAY_W-1:0]       shadow_q [NUM_MICS];
    logic [DELAY_W-1:0]       shadow_d [NUM_MICS];
    logic [DELAY_W-1:0]       active_q [NUM_MICS];
    logic [DELAY_W-1:0]       active_d [NUM_MICS];
    logic                     pend_q, pend_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic                     ram_we_c;
    logic                     ram_re_c;
    logic [DELAY_W-1:0]       ram_raddr_c;
    logic [ROW_W-1:0]         ram_rdata;
    logic [DATA_W-1:0]        lane_c;
    logic signed [ACC_W-1:0]  add_c;
    logic signed [ACC_W-1:0]  acc_sum_c;
    logic signed [ACC_W-1:0]  scaled_c;

    das_ring_ram #(
        .ADDR_W (DELAY_W),
        .WORD_W (ROW_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .re_i    (ram_re_c),
        .raddr_i (ram_raddr_c),
        .rdata_o (ram_rdata)
    );

    // Datapath: the row read last cycle contributes its own lane only.
    always_comb begin
        lane_c      = ram_rdata[rd_k_q*DATA_W +: DATA_W];
        add_c       = (rd_vld_q && !rd_zero_q) ? ACC_W'(signed'(lane_c)) : '0;
        acc_sum_c   = acc_q + add_c;
        scaled_c    = acc_sum_c >>> SHIFT;
        ram_raddr_c = base_q - active_q[k_q];
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        rd_vld_d    = 1'b0;
        rd_zero_d   = rd_zero_q;
        rd_k_d      = rd_k_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pend_d      = pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;

        if (dly_wr_en && (32'(dly_wr_idx) < NUM_MICS)) begin
            shadow_d[dly_wr_idx] = dly_wr_val;
        end

        case (state_q)
            ST_IDLE: begin
                // Commit lands before any acceptance in this same cycle reads the table.
                if (pend_q || dly_commit) begin
                    active_d = shadow_d;
                    pend_d   = 1'b0;
                end
                if (in_valid && in_ready_q) begin
                    ram_we_c   = 1'b1;
                    base_d     = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + DELAY_W'(1);
                    if (fill_q != FILL_W'(DEPTH)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                    acc_d      = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                ram_re_c  = 1'b1;
                rd_vld_d  = 1'b1;
                rd_k_d    = k_q;
                rd_zero_d = ({1'b0, active_q[k_q]} >= fill_q);
                acc_d     = acc_sum_c;
                if (k_q == IDX_W'(NUM_MICS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                acc_d       = acc_sum_c;
                out_valid_d = 1'b1;
                if (scaled_c > SAT_MAX) begin
                    out_data_d = DATA_W'(SAT_MAX);
                    out_sat_d  = 1'b1;
                end else if (scaled_c < SAT_MIN) begin
                    out_data_d = DATA_W'(SAT_MIN);
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = DATA_W'(scaled_c);
                    out_sat_d  = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        if (dly_commit && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_zero_q   <= 1'b0;
            rd_k_q      <= '0;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < NUM_MICS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            rd_vld_q    <= rd_vld_d;
            rd_zero_q   <= rd_zero_d;
            rd_k_q      <= rd_k_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign commit_pending = pend_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_sat        = out_sat_q;

endmodule

// File: tb/tb_das_beamformer.sv
// Self-checking bench for das_beamformer: a default instance against a
// history-queue reference model, plus a SHIFT=0 instance for saturation.
module tb_das_beamformer;

    localparam int N   = 9;
    localparam int DW  = 16;
    localparam int DLW = 8;
    localparam int RW  = N * DW;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [RW-1:0] in_data;
    logic          dly_wr_en;
    logic [3:0]    dly_wr_idx;
    logic [DLW-1:0] dly_wr_val;
    logic          dly_commit, commit_pending;
    logic          out_valid, out_sat;
    logic [DW-1:0] out_data;

    logic          in_valid1, in_ready1;
    logic [RW-1:0] in_data1;
    logic          dly_wr_en1;
    logic [3:0]    dly_wr_idx1;
    logic [DLW-1:0] dly_wr_val1;
    logic          dly_commit1, commit_pending1;
    logic          out_valid1, out_sat1;
    logic [DW-1:0] out_data1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    logic [RW-1:0] hist [$];
    int  sh [N];
    int  ac [N];
    bit  pend_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    das_beamformer #(.DATA_W(DW), .NUM_MICS(N), .DELAY_W(DLW), .SHIFT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dly_wr_en(dly_wr_en), .dly_wr_idx(dly_wr_idx), .dly_wr_val(dly_wr_val),
        .dly_commit(dly_commit), .commit_pending(commit_pending),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    das_beamformer #(.DATA_W(DW), .NUM_MICS(N), .DELAY_W(DLW), .SHIFT(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .dly_wr_en(dly_wr_en1), .dly_wr_idx(dly_wr_idx1), .dly_wr_val(dly_wr_val1),
        .dly_commit(dly_commit1), .commit_pending(commit_pending1),
        .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1)
    );

    // Reference: output n sums lane k of sample n-dly[k], if that sample exists.
    function automatic void model(output int od, output bit os);
        int     n    = hist.size();
        int     fill = (n > 256) ? 256 : n;
        longint s    = 0;
        for (int k = 0; k < N; k++) begin
            logic [RW-1:0]        row;
            logic signed [DW-1:0] v;
            if (ac[k] < fill) begin
                row = hist[n - 1 - ac[k]];
                v   = row[k*DW +: DW];
                s  += longint'(v);
            end
        end
        s  = s >>> 4;
        os = 1'b0;
        if (s > 32767)       begin s = 32767;  os = 1'b1; end
        else if (s < -32768) begin s = -32768; os = 1'b1; end
        od = int'(s);
    endfunction

    function automatic logic [RW-1:0] fill_vec(input int val);
        logic [RW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_vec();
        logic [RW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic reset_dut();
        in_valid = 0; in_data = '0; dly_wr_en = 0; dly_wr_idx = '0; dly_wr_val = '0; dly_commit = 0;
        in_valid1 = 0; in_data1 = '0; dly_wr_en1 = 0; dly_wr_idx1 = '0; dly_wr_val1 = '0; dly_commit1 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        hist.delete();
        for (int k = 0; k < N; k++) begin sh[k] = 0; ac[k] = 0; end
        pend_m = 0;
    endtask

    task automatic accept(input logic [RW-1:0] v);
        int w = 0;
        while (in_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
        if (w >= 100) begin
            bad++; total++;
            $display("FAIL accept_timeout: in_ready never rose after %0d cycles", w);
        end
        in_valid = 1; in_data = v;
        @(posedge clk); #1;
        in_valid = 0;
        acc_cyc = cyc;
        if (pend_m) begin ac = sh; pend_m = 0; end
        hist.push_back(v);
    endtask

    task automatic collect(output logic [DW-1:0] od, output logic os, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) begin lat = cyc - acc_cyc + 1; break; end
            @(posedge clk); #1;
        end
        od = out_data; os = out_sat;
    endtask

    task automatic write_dly(input int idx, input int val, input bit with_commit, input bit idle);
        dly_wr_en = 1; dly_wr_idx = 4'(idx); dly_wr_val = DLW'(val); dly_commit = with_commit;
        @(posedge clk); #1;
        dly_wr_en = 0; dly_commit = 0;
        if (idx < N) sh[idx] = val;
        if (with_commit) begin
            if (idle) begin ac = sh; pend_m = 0; end
            else pend_m = 1;
        end
    endtask

    task automatic accept1(input logic [RW-1:0] v);
        int w = 0;
        while (in_ready1 !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
        in_valid1 = 1; in_data1 = v;
        @(posedge clk); #1;
        in_valid1 = 0;
    endtask

    task automatic collect1(output logic [DW-1:0] od, output logic os, output bit seen);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid1 === 1'b1) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        od = out_data1; os = out_sat1;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready_s0: got %b want 1", in_ready1); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] od; logic os; int lat;
        accept(fill_vec(16));
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: in_ready got %b want 0", in_ready); end
        collect(od, os, lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        total++; if (od !== 16'd9) begin bad++; $display("FAIL basic_data: got %0d want 9", $signed(od)); end
        total++; if (os !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", os); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b want 0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", out_valid); end
        total++; if (out_data !== 16'd9) begin bad++; $display("FAIL basic_hold: got %0d want 9", $signed(out_data)); end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] od; logic os; int lat; logic [RW-1:0] v; int exp;
        reset_dut();
        for (int k = 0; k < N; k++) write_dly(k, k, k == N - 1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            v = '0;
            for (int k = 0; k < N; k++) if (i == 10 - k) v[k*DW +: DW] = 16'd160;
            accept(v);
            collect(od, os, lat);
            exp = (i == 10) ? 90 : 0;
            total++;
            if (lat != LAT || od !== 16'(exp) || os !== 1'b0) begin
                bad++;
                $display("FAIL impulse_s%0d: got %0d sat=%b lat=%0d want %0d sat=0 lat=%0d", i, $signed(od), os, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_sat();
        logic [DW-1:0] od; logic os; bit seen; logic [RW-1:0] v; longint s; int e; bit es;
        int vals [4] = '{32767, -32768, 1000, -3000};
        int exps [4] = '{32767, -32768, 9000, -27000};
        bit sats [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            accept1(fill_vec(vals[i]));
            collect1(od, os, seen);
            total++;
            if (!seen || od !== 16'(exps[i]) || os !== sats[i]) begin
                bad++;
                $display("FAIL sat_fixed%0d: got %0d sat=%b seen=%b want %0d sat=%b", i, $signed(od), os, seen, exps[i], sats[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            v = rand_vec();
            s = 0;
            for (int k = 0; k < N; k++) s += longint'($signed(v[k*DW +: DW]));
            es = (s > 32767 || s < -32768);
            e  = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
            accept1(v);
            collect1(od, os, seen);
            total++;
            if (!seen || od !== 16'(e) || os !== es) begin
                bad++;
                $display("FAIL sat_rand%0d: got %0d sat=%b want %0d sat=%b", i, $signed(od), os, e, es);
            end
        end
    endtask

    task automatic test_commit_during_read();
        logic [DW-1:0] od; logic os; int lat; int e; bit es;
        accept(rand_vec());
        @(posedge clk); #1;
        write_dly(0, 3, 1'b0, 1'b0);
        write_dly(1, 7, 1'b0, 1'b0);
        write_dly(2, 1, 1'b1, 1'b0);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL commit_pending_set: got %b want 1", commit_pending); end
        collect(od, os, lat);
        model(e, es);
        total++;
        if (lat != LAT || od !== 16'(e) || os !== es) begin
            bad++; $display("FAIL commit_old_table: got %0d lat=%0d want %0d lat=%0d", $signed(od), lat, e, LAT);
        end
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL commit_pending_hold: got %b want 1", commit_pending); end
        accept(rand_vec());
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL commit_pending_clear: got %b want 0", commit_pending); end
        collect(od, os, lat);
        model(e, es);
        total++;
        if (lat != LAT || od !== 16'(e) || os !== es) begin
            bad++; $display("FAIL commit_new_table: got %0d lat=%0d want %0d lat=%0d", $signed(od), lat, e, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] od; logic os; int lat; int e; bit es;
        for (int k = 0; k < N; k++) write_dly(k, $urandom_range(0, 20), 1'b0, 1'b1);
        write_dly($urandom_range(N, 15), $urandom_range(1, 255), 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) begin
                write_dly($urandom_range(0, N - 1), $urandom_range(0, 40), 1'b0, 1'b1);
                write_dly($urandom_range(0, N - 1), $urandom_range(0, 40), 1'b1, 1'b1);
            end
            accept(rand_vec());
            collect(od, os, lat);
            model(e, es);
            total++;
            if (lat != LAT || od !== 16'(e) || os !== es) begin
                bad++;
                $display("FAIL random_v%0d: got %0d sat=%b lat=%0d want %0d sat=%b lat=%0d", i, $signed(od), os, lat, e, es, LAT);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_long_delay();
        logic [DW-1:0] od; logic os; int lat; logic [RW-1:0] v; int exp;
        reset_dut();
        write_dly(0, 255, 1'b1, 1'b1);
        v = '0;
        v[DW-1:0] = 16'd100;
        for (int i = 0; i < 257; i++) begin
            accept(v);
            collect(od, os, lat);
            exp = (i >= 255) ? 6 : 0;
            total++;
            if (lat != LAT || od !== 16'(exp) || os !== 1'b0) begin
                bad++;
                $display("FAIL long_delay_s%0d: got %0d sat=%b lat=%0d want %0d", i + 1, $signed(od), os, lat, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] od; logic os; int lat; bit seen; int e; bit es;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) write_dly(k, 5, k == N - 1, 1'b1);
        accept(fill_vec(1000));
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL rstmid_pending: got %b want 0", commit_pending); end
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL rstmid_no_output: got out_valid=1 want none"); end
        hist.delete();
        for (int k = 0; k < N; k++) begin sh[k] = 0; ac[k] = 0; end
        pend_m = 0;
        accept(fill_vec(16));
        collect(od, os, lat);
        model(e, es);
        total++;
        if (lat != LAT || od !== 16'd9 || od !== 16'(e) || os !== 1'b0) begin
            bad++; $display("FAIL rstmid_after: got %0d lat=%0d want 9 lat=%0d", $signed(od), lat, LAT);
        end
    endtask

    initial begin
        reset_dut();
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_impulse();
        test_sat();
        test_commit_during_read();
        test_random();
        test_long_delay();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
